// File: rtl/tone_source_arbiter.sv
// Chooses the tone generator's note source (keypad or sequencer) and commits note changes on waveform boundaries.
// Optional build macro: TONE_ARB_LAST_PRIORITY_EN selects last-pressed key priority; default is lowest-index held key.
module tone_source_arbiter #(
  parameter int NKEYS       = 13,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NKEYS-1:0] key_in,
  input  logic [3:0]       seq_note,
  input  logic             wave_edge,
  output logic [3:0]       note_out,
  output logic [1:0]       src,
  output logic             note_chg,
  output logic [1:0]       state_dbg
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    SILENT    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_HOLD = 2'd2,
    ST_SEQ  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    active_key_q, active_key_d;
  logic [3:0]    note_out_q, note_out_d;
  logic [1:0]    src_q, src_d;
  logic          note_chg_q, note_chg_d;
  logic [3:0]    target;
  logic [3:0]    low_idx;
  logic          any_key;

  assign any_key = |key_in;

  always_comb begin
    low_idx = 4'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (key_in[i]) low_idx = 4'(i);
    end
  end

`ifdef TONE_ARB_LAST_PRIORITY_EN
  logic [NKEYS-1:0] key_prev_q;
  logic [NKEYS-1:0] new_press;
  logic [3:0]       high_new_idx;
  logic             act_held;

  assign new_press = key_in & ~key_prev_q;

  always_comb begin
    high_new_idx = 4'd0;
    act_held     = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (new_press[i]) high_new_idx = 4'(i);
      if (active_key_q == 4'(i)) act_held = key_in[i];
    end
    active_key_d = active_key_q;
    if (|new_press) begin
      active_key_d = high_new_idx;
    end else if (!act_held && any_key) begin
      active_key_d = low_idx;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) key_prev_q <= '0;
    else        key_prev_q <= key_in;
  end
`else
  always_comb begin
    active_key_d = active_key_q;
    if (any_key) active_key_d = low_idx;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    target  = SILENT;
    case (state_q)
      ST_IDLE: begin
        if (any_key)                  state_d = ST_KEY;
        else if (seq_note != SILENT)  state_d = ST_SEQ;
      end
      ST_KEY: begin
        target = active_key_q;
        if (!any_key) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (any_key) begin
          state_d = ST_KEY;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = (seq_note != SILENT) ? ST_SEQ : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SEQ: begin
        target = seq_note;
        if (any_key)                  state_d = ST_KEY;
        else if (seq_note == SILENT)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Target comes from the pre-edge state, so a coincident state change commits on the next opportunity.
  always_comb begin
    note_out_d = note_out_q;
    note_chg_d = 1'b0;
    if ((target != note_out_q) && ((note_out_q == SILENT) || wave_edge)) begin
      note_out_d = target;
      note_chg_d = 1'b1;
    end
    case (state_d)
      ST_KEY:  src_d = 2'b01;
      ST_SEQ:  src_d = 2'b10;
      default: src_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      active_key_q <= 4'd0;
      note_out_q   <= SILENT;
      src_q        <= 2'b00;
      note_chg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_key_q <= active_key_d;
      note_out_q   <= note_out_d;
      src_q        <= src_d;
      note_chg_q   <= note_chg_d;
    end
  end

  assign note_out  = note_out_q;
  assign src       = src_q;
  assign note_chg  = note_chg_q;
  assign state_dbg = state_q;

endmodule
